// File: rtl/div_unit.sv
// Radix-2 restoring divider for MIPS DIV/DIVU in the execute stage.
// Holds the pipeline through div_stall while iterating; honours E-stage flush.
module div_unit #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             signed_div,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    input  logic             flush,
    input  logic             stall_other,
    output logic             div_stall,
    output logic             result_valid,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder
);

    localparam int CW = $clog2(WIDTH) + 1;

    typedef enum logic [1:0] {
        IDLE,
        BUSY,
        DONE
    } state_t;

    state_t           state, state_n;
    logic [CW-1:0]    cnt, cnt_n;
    logic [WIDTH-1:0] rem, rem_n;
    logic [WIDTH-1:0] quo, quo_n;
    logic [WIDTH-1:0] dvsr, dvsr_n;
    logic [WIDTH-1:0] quotient_n, remainder_n;
    logic             q_neg, q_neg_n;
    logic             r_neg, r_neg_n;

    logic             a_neg, b_neg;
    logic [WIDTH-1:0] a_mag, b_mag;
    logic [WIDTH:0]   rem_sh, diff;
    logic [WIDTH-1:0] step_rem, step_quo;

    assign a_neg = signed_div & dividend[WIDTH-1];
    assign b_neg = signed_div & divisor[WIDTH-1];
    assign a_mag = a_neg ? -dividend : dividend;
    assign b_mag = b_neg ? -divisor : divisor;

    // One restoring step: shift {rem, quo} and trial-subtract in WIDTH+1 bits.
    always_comb begin
        rem_sh = {rem, quo[WIDTH-1]};
        diff   = rem_sh - {1'b0, dvsr};
        if (!diff[WIDTH]) begin
            step_rem = diff[WIDTH-1:0];
            step_quo = {quo[WIDTH-2:0], 1'b1};
        end else begin
            step_rem = rem_sh[WIDTH-1:0];
            step_quo = {quo[WIDTH-2:0], 1'b0};
        end
    end

    always_comb begin
        state_n     = state;
        cnt_n       = cnt;
        rem_n       = rem;
        quo_n       = quo;
        dvsr_n      = dvsr;
        q_neg_n     = q_neg;
        r_neg_n     = r_neg;
        quotient_n  = quotient;
        remainder_n = remainder;
        if (flush) begin
            state_n = IDLE;
        end else begin
            unique case (state)
                IDLE: begin
                    if (start) begin
                        q_neg_n = a_neg ^ b_neg;
                        r_neg_n = a_neg;
                        if (divisor == '0) begin
                            state_n     = DONE;
                            quotient_n  = '1;
                            remainder_n = dividend;
                        end else begin
                            state_n = BUSY;
                            cnt_n   = CW'(WIDTH);
                            rem_n   = '0;
                            quo_n   = a_mag;
                            dvsr_n  = b_mag;
                        end
                    end
                end
                BUSY: begin
                    rem_n = step_rem;
                    quo_n = step_quo;
                    cnt_n = cnt - 1'b1;
                    if (cnt == CW'(1)) begin
                        state_n     = DONE;
                        quotient_n  = q_neg ? -step_quo : step_quo;
                        remainder_n = r_neg ? -step_rem : step_rem;
                    end
                end
                DONE: begin
                    if (!stall_other) state_n = IDLE;
                end
                default: state_n = IDLE;
            endcase
        end
    end

    assign div_stall = ~flush & ((state == IDLE & start) | (state == BUSY));

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= IDLE;
            cnt          <= '0;
            rem          <= '0;
            quo          <= '0;
            dvsr         <= '0;
            q_neg        <= 1'b0;
            r_neg        <= 1'b0;
            quotient     <= '0;
            remainder    <= '0;
            result_valid <= 1'b0;
        end else begin
            state        <= state_n;
            cnt          <= cnt_n;
            rem          <= rem_n;
            quo          <= quo_n;
            dvsr         <= dvsr_n;
            q_neg        <= q_neg_n;
            r_neg        <= r_neg_n;
            quotient     <= quotient_n;
            remainder    <= remainder_n;
            result_valid <= (state_n == DONE);
        end
    end

endmodule

// File: tb/tb_div_unit.sv
// Directed testbench for div_unit: timing, signed/unsigned results,
// divide-by-zero, flush, stall_other hold, back-to-back and reset abort.
module tb_div_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic        signed_div;
    logic [31:0] dividend;
    logic [31:0] divisor;
    logic        flush;
    logic        stall_other;
    logic        div_stall;
    logic        result_valid;
    logic [31:0] quotient;
    logic [31:0] remainder;

    int total = 0;
    int bad   = 0;
    int n, st, n2, st2, seen;
    logic [31:0] q_hold, r_hold;

    always #5 clk = ~clk;

    div_unit #(.WIDTH(32)) dut (
        .clk          (clk),
        .rst          (rst),
        .start        (start),
        .signed_div   (signed_div),
        .dividend     (dividend),
        .divisor      (divisor),
        .flush        (flush),
        .stall_other  (stall_other),
        .div_stall    (div_stall),
        .result_valid (result_valid),
        .quotient     (quotient),
        .remainder    (remainder)
    );

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Called at a negedge; that cycle is cycle 0. Returns at the negedge of
    // the first result_valid cycle (n = its cycle index, st = stall cycles).
    task automatic run_div(input logic sd, input logic [31:0] a,
                           input logic [31:0] b, output int cyc,
                           output int stalls);
        start      = 1'b1;
        signed_div = sd;
        dividend   = a;
        divisor    = b;
        cyc        = 0;
        stalls     = 0;
        #1;
        while (!result_valid && cyc < 100) begin
            if (div_stall) stalls++;
            @(negedge clk);
            cyc++;
            dividend = $urandom;
            divisor  = $urandom;
            #1;
        end
    endtask

    initial begin
        rst         = 1'b1;
        start       = 1'b0;
        signed_div  = 1'b0;
        dividend    = '0;
        divisor     = '0;
        flush       = 1'b0;
        stall_other = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        #1;
        chk("rst_valid", {31'd0, result_valid}, 32'd0);
        chk("rst_quo", quotient, 32'd0);
        chk("rst_rem", remainder, 32'd0);
        chk("rst_stall", {31'd0, div_stall}, 32'd0);

        @(negedge clk);
        run_div(1'b0, 32'd100, 32'd7, n, st);
        chk("divu_cyc", n, 32'd33);
        chk("divu_stalls", st, 32'd33);
        chk("divu_quo", quotient, 32'd14);
        chk("divu_rem", remainder, 32'd2);
        chk("divu_done_stall", {31'd0, div_stall}, 32'd0);
        @(negedge clk);
        start = 1'b0;
        #1;
        chk("divu_idle_valid", {31'd0, result_valid}, 32'd0);
        chk("divu_idle_stall", {31'd0, div_stall}, 32'd0);

        @(negedge clk);
        run_div(1'b1, 32'hFFFF_FFF9, 32'd2, n, st);
        chk("div_m7_2_quo", quotient, 32'hFFFF_FFFD);
        chk("div_m7_2_rem", remainder, 32'hFFFF_FFFF);
        @(negedge clk);
        start = 1'b0;

        @(negedge clk);
        run_div(1'b1, 32'd7, 32'hFFFF_FFFE, n, st);
        chk("div_7_m2_quo", quotient, 32'hFFFF_FFFD);
        chk("div_7_m2_rem", remainder, 32'd1);
        @(negedge clk);
        start = 1'b0;

        @(negedge clk);
        run_div(1'b1, 32'h8000_0000, 32'hFFFF_FFFF, n, st);
        chk("ovf_quo", quotient, 32'h8000_0000);
        chk("ovf_rem", remainder, 32'd0);
        @(negedge clk);
        start = 1'b0;

        @(negedge clk);
        run_div(1'b0, 32'd5, 32'd0, n, st);
        chk("dz_cyc", n, 32'd1);
        chk("dz_stalls", st, 32'd1);
        chk("dz_quo", quotient, 32'hFFFF_FFFF);
        chk("dz_rem", remainder, 32'd5);
        @(negedge clk);
        start = 1'b0;

        @(negedge clk);
        start      = 1'b1;
        signed_div = 1'b0;
        dividend   = 32'd100;
        divisor    = 32'd7;
        repeat (10) @(negedge clk);
        flush = 1'b1;
        start = 1'b0;
        #1;
        chk("flush_stall", {31'd0, div_stall}, 32'd0);
        @(negedge clk);
        flush = 1'b0;
        #1;
        chk("flush_idle_stall", {31'd0, div_stall}, 32'd0);
        seen = 0;
        repeat (40) begin
            if (result_valid) seen++;
            @(negedge clk);
        end
        chk("flush_no_valid", seen, 32'd0);
        run_div(1'b0, 32'd9, 32'd3, n, st);
        chk("post_flush_quo", quotient, 32'd3);
        chk("post_flush_rem", remainder, 32'd0);
        @(negedge clk);
        start = 1'b0;

        @(negedge clk);
        run_div(1'b0, 32'd1000, 32'd33, n, st);
        stall_other = 1'b1;
        q_hold = quotient;
        r_hold = remainder;
        chk("so_quo", q_hold, 32'd30);
        chk("so_rem", r_hold, 32'd10);
        for (int k = 1; k <= 4; k++) begin
            @(negedge clk);
            #1;
            chk("so_valid", {31'd0, result_valid}, 32'd1);
            chk("so_quo_hold", quotient, q_hold);
            chk("so_rem_hold", remainder, r_hold);
            if (k == 4) begin
                stall_other = 1'b0;
                start       = 1'b0;
            end
        end
        @(negedge clk);
        #1;
        chk("so_release", {31'd0, result_valid}, 32'd0);

        @(negedge clk);
        run_div(1'b0, 32'd50, 32'd6, n, st);
        chk("b2b1_quo", quotient, 32'd8);
        chk("b2b1_rem", remainder, 32'd2);
        @(negedge clk);
        run_div(1'b1, 32'hFFFF_FF9C, 32'd7, n2, st2);
        chk("b2b_spacing", n2 + 1, 32'd34);
        chk("b2b2_quo", quotient, 32'hFFFF_FFF2);
        chk("b2b2_rem", remainder, 32'hFFFF_FFFE);
        @(negedge clk);
        start = 1'b0;

        @(negedge clk);
        start      = 1'b1;
        signed_div = 1'b0;
        dividend   = 32'd77;
        divisor    = 32'd5;
        repeat (10) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("rst_mid_valid", {31'd0, result_valid}, 32'd0);
        chk("rst_mid_quo", quotient, 32'd0);
        chk("rst_mid_rem", remainder, 32'd0);
        chk("rst_mid_stall1", {31'd0, div_stall}, 32'd1);
        start = 1'b0;
        #1;
        chk("rst_mid_stall0", {31'd0, div_stall}, 32'd0);
        seen = 0;
        repeat (40) begin
            @(negedge clk);
            if (result_valid) seen++;
        end
        chk("rst_mid_no_valid", seen, 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
